seq_detector_prog: RTL

Runtime-programmable serial pattern detector and the parametrised successor to the fixed six-state `110011` sequence FSM. It accepts one bit per qualified clock and compares a history shift register against a loadable pattern of 1..MAX_LEN bits. It supports overlapping and non-overlapping match modes and keeps a saturating match counter. It sits on the serial-input path in front of the event-logging logic.

---
 rtl/seq_detector_prog_if.sv | 28 ++
 rtl/seq_detector_prog.sv | 71 +++++++
 2 files changed

// File: rtl/seq_detector_prog_if.sv
// seq_detector_prog_if: serial-input, configuration and result bundle for seq_detector_prog
//   master: drives in_valid, x, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clear
//   slave : drives z, match_count, count_sat, cfg_err
interface seq_detector_prog_if #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8
);
   localparam int LEN_W = $clog2(MAX_LEN + 1);
   logic               in_valid;
   logic               x;
   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               clear;
   logic               z;
   logic [CNT_W-1:0]   match_count;
   logic               count_sat;
   logic               cfg_err;
   modport master (
      output in_valid, x, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clear,
      input  z, match_count, count_sat, cfg_err
   );
   modport slave (
      input  in_valid, x, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clear,
      output z, match_count, count_sat, cfg_err
   );
endinterface

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: runtime-programmable serial pattern detector with saturating match counter
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : seq_detector_prog_if.slave (serial input, config load, clear, z/count/sat/err results)
module seq_detector_prog #(
   parameter int                 MAX_LEN       = 8,
   parameter int                 CNT_W         = 8,
   parameter logic [MAX_LEN-1:0] RESET_PATTERN = 8'b0011_0011,
   parameter int                 RESET_LEN     = 6,
   parameter bit                 RESET_OVERLAP = 1'b1
) (
   input logic                clk,
   input logic                reset_n,
   seq_detector_prog_if.slave bus
);
   localparam int LEN_W = $clog2(MAX_LEN + 1);
   logic [MAX_LEN-1:0] hist, pat, mask, new_hist;
   logic [LEN_W-1:0]   fill, len, new_fill;
   logic               ovl, err, z, sat, hit;
   logic [CNT_W-1:0]   cnt, cnt_inc;
   assign new_hist = {hist[MAX_LEN-2:0], bus.x};
   assign new_fill = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
   assign cnt_inc  = (cnt == '1) ? cnt : cnt + CNT_W'(1);
   // only the low len bits of history take part in the compare
   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++)
         mask[i] = (i < int'(len));
   end
   // err gates the match so an illegal (e.g. zero) length can never fire
   assign hit = bus.in_valid && !bus.cfg_load && !err && new_fill >= len &&
                ((new_hist ^ pat) & mask) == '0;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist <= '0;
         fill <= '0;
         pat  <= RESET_PATTERN;
         len  <= LEN_W'(RESET_LEN);
         ovl  <= RESET_OVERLAP;
         err  <= 1'b0;
         z    <= 1'b0;
         cnt  <= '0;
         sat  <= 1'b0;
      end else if (bus.cfg_load) begin
         pat  <= bus.cfg_pattern;
         len  <= bus.cfg_len;
         ovl  <= bus.cfg_overlap;
         err  <= bus.cfg_len == '0 || bus.cfg_len > LEN_W'(MAX_LEN);
         hist <= '0;
         fill <= '0;
         z    <= 1'b0;
      end else begin
         z <= hit;
         if (bus.in_valid) begin
            hist <= new_hist;
            fill <= (hit && !ovl) ? '0 : new_fill;
         end
         if (bus.clear) begin
            cnt <= '0;
            sat <= 1'b0;
         end else if (hit) begin
            cnt <= cnt_inc;
            sat <= sat | (cnt_inc == '1);
         end
      end
   end
   assign bus.z           = z;
   assign bus.match_count = cnt;
   assign bus.count_sat   = sat;
   assign bus.cfg_err     = err;
endmodule
